// File: rtl/uart_baud_frac_pkg.sv
// uart_pkg: shared UART baud configuration types and constants
package uart_pkg;
    localparam int BAUD_DIV_MIN      = 2;
    localparam int BAUD_DEF_DIV_INT  = 27;
    localparam int BAUD_DEF_DIV_FRAC = 2;
    typedef struct packed {
        logic [15:0] div_int;
        logic [3:0]  div_frac;
    } baud_cfg_t;
    function automatic int ph_width(input int ovs);
        return (ovs > 1) ? $clog2(ovs) : 1;
    endfunction
endpackage

// File: rtl/uart_baud_frac_if.sv
// uart_baud_frac_if: control, divisor reload and tick outputs of the baud generator
interface uart_baud_frac_if
    import uart_pkg::*;
#(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4,
    parameter int OVS    = 16
);
    localparam int PH_W = ph_width(OVS);
    logic              en;
    logic              restart;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              div_load;
    logic              div_ack;
    logic              cfg_err;
    logic              tick_os;
    logic              tick_bit;
    logic [PH_W-1:0]   os_phase;
    modport master (
        output en, restart, div_int, div_frac, div_load,
        input  div_ack, cfg_err, tick_os, tick_bit, os_phase
    );
    modport slave (
        input  en, restart, div_int, div_frac, div_load,
        output div_ack, cfg_err, tick_os, tick_bit, os_phase
    );
endinterface

// File: rtl/uart_baud_frac_acc.sv
// baud_frac_acc: fractional accumulator; carry stretches the next period by one clock
module baud_frac_acc #(
    parameter int FRAC_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_clr,
    input  logic              i_stb,
    input  logic [FRAC_W-1:0] i_frac,
    output logic              o_ext
);
    logic [FRAC_W-1:0] r_acc;
    logic              r_ext;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            r_acc <= '0;
            r_ext <= 1'b0;
        end else if (i_clr) begin
            r_acc <= '0;
            r_ext <= 1'b0;
        end else if (i_stb) begin
            {r_ext, r_acc} <= {1'b0, r_acc} + {1'b0, i_frac};
        end
    assign o_ext = r_ext;
endmodule

// File: rtl/uart_baud_frac.sv
// uart_baud_frac: fractional baud generator producing oversample and bit ticks
module uart_baud_frac
    import uart_pkg::*;
#(
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = 4,
    parameter int OVS          = 16,
    parameter int RST_DIV_INT  = BAUD_DEF_DIV_INT,
    parameter int RST_DIV_FRAC = BAUD_DEF_DIV_FRAC
) (
    input logic             clk,
    input logic             reset_n,
    uart_baud_frac_if.slave bus
);
    localparam int PH_W = ph_width(OVS);
    logic [DIV_W-1:0]  r_cnt;
    logic [DIV_W-1:0]  r_act_int;
    logic [FRAC_W-1:0] r_act_frac;
    logic [DIV_W-1:0]  r_pend_int;
    logic [FRAC_W-1:0] r_pend_frac;
    logic              r_pend;
    logic [PH_W-1:0]   r_phase;
    logic              r_tick_os;
    logic              r_tick_bit;
    logic              r_ack;
    logic              r_cfg_err;
    logic              w_ext;
    logic [DIV_W-1:0]  w_term;
    logic              w_end;
    logic              w_apply;
    logic              w_legal;
    logic              w_rej;
    logic              w_wrap;
    assign w_term  = r_act_int - DIV_W'(1) + DIV_W'(w_ext);
    assign w_end   = bus.en && !bus.restart && r_cnt == w_term;
    // pending divisor lands on a period boundary, a restart, or any idle cycle
    assign w_apply = r_pend && (bus.restart || w_end || !bus.en);
    assign w_legal = bus.div_load && bus.div_int >= DIV_W'(BAUD_DIV_MIN);
    assign w_rej   = bus.div_load && !w_legal;
    assign w_wrap  = r_phase == PH_W'(OVS - 1);
    baud_frac_acc #(.FRAC_W(FRAC_W)) u_acc (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (bus.restart),
        .i_stb   (w_end),
        .i_frac  (r_act_frac),
        .o_ext   (w_ext)
    );
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            r_cnt       <= '0;
            r_act_int   <= DIV_W'(RST_DIV_INT);
            r_act_frac  <= FRAC_W'(RST_DIV_FRAC);
            r_pend_int  <= '0;
            r_pend_frac <= '0;
            r_pend      <= 1'b0;
            r_phase     <= '0;
            r_tick_os   <= 1'b0;
            r_tick_bit  <= 1'b0;
            r_ack       <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_cnt      <= (bus.restart || w_end) ? '0 : bus.en ? r_cnt + DIV_W'(1) : r_cnt;
            r_phase    <= bus.restart ? '0 : !w_end ? r_phase : w_wrap ? '0 : r_phase + PH_W'(1);
            r_tick_os  <= w_end;
            r_tick_bit <= w_end && w_wrap;
            r_ack      <= w_apply || w_rej;
            r_cfg_err  <= w_rej ? 1'b1 : w_apply ? 1'b0 : r_cfg_err;
            r_pend     <= w_legal || (r_pend && !w_apply);
            if (w_apply) begin
                r_act_int  <= r_pend_int;
                r_act_frac <= r_pend_frac;
            end
            if (w_legal) begin
                r_pend_int  <= bus.div_int;
                r_pend_frac <= bus.div_frac;
            end
        end
    assign bus.tick_os  = r_tick_os;
    assign bus.tick_bit = r_tick_bit;
    assign bus.os_phase = r_phase;
    assign bus.div_ack  = r_ack;
    assign bus.cfg_err  = r_cfg_err;
endmodule
